alu_stage: RTL

//   Registered ALU stage with valid/ready handshake on both sides.

---
 rtl/alu_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_stage.sv
// Registered ALU stage with a main + skid output buffer, so in_ready depends only on registered state.
// Results travel together with their zf/nf/cf/vf flags as one packed beat.
module alu_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output logic             vf
);

    localparam int RW = WIDTH + 4;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // Beat layout: {y, zf, nf, cf, vf}
    function automatic logic [RW-1:0] alu_calc(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        sum = {(WIDTH+1){1'b0}};
        r   = {WIDTH{1'b0}};
        c   = 1'b0;
        v   = 1'b0;
        case (f_op)
            3'b000: r = fa & fb;
            3'b001: r = fa | fb;
            3'b010: r = fa ^ fb;
            3'b011: r = ~fa;
            3'b100: begin
                sum = {1'b0, fa} + {1'b0, fb};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (fa[WIDTH-1] == fb[WIDTH-1]) && (r[WIDTH-1] != fa[WIDTH-1]);
            end
            3'b101: begin
                // Carry-out of a + ~b + 1: set means no borrow occurred.
                sum = {1'b0, fa} + {1'b0, ~fb} + {{WIDTH{1'b0}}, 1'b1};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (fa[WIDTH-1] != fb[WIDTH-1]) && (r[WIDTH-1] != fa[WIDTH-1]);
            end
            3'b110: r = {{(WIDTH-1){1'b0}}, &fa};
            default: r = {WIDTH{1'b0}};
        endcase
        return {r, (r == {WIDTH{1'b0}}), r[WIDTH-1], c, v};
    endfunction

    state_t         state_q, state_d;
    logic [RW-1:0]  main_q, main_d;
    logic [RW-1:0]  skid_q, skid_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [RW-1:0]  result_s;
    logic           accept_s;
    logic           drain_s;

    assign result_s = alu_calc(op, a, b);
    assign accept_s = in_valid & in_ready_q;
    assign drain_s  = out_valid_q & out_ready;

    // Buffer next-state and data steering
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept_s) begin
                    main_d  = result_s;
                    state_d = S_ONE;
                end else begin
                    state_d = S_EMPTY;
                end
            end
            S_ONE: begin
                if (accept_s && !drain_s) begin
                    skid_d  = result_s;
                    state_d = S_TWO;
                end else if (drain_s && !accept_s) begin
                    state_d = S_EMPTY;
                end else if (accept_s && drain_s) begin
                    main_d  = result_s;
                end else begin
                    state_d = S_ONE;
                end
            end
            S_TWO: begin
                if (drain_s) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end else begin
                    state_d = S_TWO;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        in_ready_d  = (state_d != S_TWO);
        out_valid_d = (state_d != S_EMPTY);
    end

    // State, buffer and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_q      <= {RW{1'b0}};
            skid_q      <= {RW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = main_q[RW-1:4];
    assign zf        = main_q[3];
    assign nf        = main_q[2];
    assign cf        = main_q[1];
    assign vf        = main_q[0];

endmodule
